// File: rtl/audio_sample_reader_if.sv
// Memory read port and outgoing sample stream of audio_sample_reader.
interface audio_sample_reader_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write;
    logic [3:0]        avm_byteenable;
    logic [DATA_W-1:0] avm_readdata;
    logic [DATA_W-1:0] src_data;
    logic              src_valid;
    logic              src_ready;

    // Stream: a word moves on every cycle with src_valid && src_ready; src_valid never waits on src_ready
    // and src_data holds while src_valid is high and not yet accepted.
    modport master (
        output avm_address, avm_chipselect, avm_write, avm_byteenable, src_data, src_valid,
        input  avm_readdata, src_ready
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write, avm_byteenable, src_data, src_valid,
        output avm_readdata, src_ready
    );
endinterface

// File: rtl/audio_sample_reader.sv
// Avalon-MM read master streaming sample words from on-chip memory through a prefetch FIFO.
// Continuous replay of the buffer is compiled in only when SAMPLE_READER_LOOP_EN is defined.
module audio_sample_reader #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 32000,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       num_words,
    audio_sample_reader_if.master bus,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FLUSH = 2'd3
    } state_t;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W + 1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d, issue_addr;
    logic [ADDR_W:0]     rem_q, rem_d, rem_after;
    logic                issue, fifo_clear, done_d;
    logic [READ_LATENCY-1:0] rd_pipe;
    logic [OCC_W-1:0]    in_flight, occupancy;

    logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic                fifo_nempty, fifo_wr, fifo_pop;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

`ifdef SAMPLE_READER_LOOP_EN
    logic              loop_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   num_q;
    logic              reload_loop;
    logic [ADDR_W-1:0] reload_base;
    logic [ADDR_W:0]   reload_num;

    // On the start cycle the reload source is the live inputs, so even a one-word buffer loops gap-free.
    assign reload_loop = (state_q == S_IDLE) ? loop      : loop_q;
    assign reload_base = (state_q == S_IDLE) ? base_addr : base_q;
    assign reload_num  = (state_q == S_IDLE) ? num_words : num_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            loop_q <= 1'b0;
            base_q <= '0;
            num_q  <= '0;
        end else if (state_q == S_IDLE && start) begin
            loop_q <= loop;
            base_q <= base_addr;
            num_q  <= num_words;
        end
    end
`else
    logic unused_loop;
    assign unused_loop = loop;
`endif

    // Reads already committed: the one on the bus this cycle plus those still in the latency pipe.
    always_comb begin
        in_flight = OCC_W'(bus.avm_chipselect);
        for (int i = 0; i < READ_LATENCY; i++) begin
            in_flight = in_flight + OCC_W'(rd_pipe[i]);
        end
        occupancy = in_flight + OCC_W'(fifo_cnt);
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        issue      = 1'b0;
        issue_addr = addr_q;
        rem_after  = rem_q;
        fifo_clear = 1'b0;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (num_words == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = S_RUN;
                        issue      = 1'b1;
                        issue_addr = base_addr;
                        rem_after  = num_words - REM_ONE;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d    = S_FLUSH;
                    fifo_clear = 1'b1;
                end else if (rem_q == '0) begin
                    state_d = S_DRAIN;
                end else if (occupancy < OCC_W'(FIFO_DEPTH)) begin
                    issue     = 1'b1;
                    rem_after = rem_q - REM_ONE;
                end
            end
            S_DRAIN: begin
                if (stop) begin
                    state_d    = S_FLUSH;
                    fifo_clear = 1'b1;
                end else if (in_flight == '0 && fifo_cnt == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_FLUSH: begin
                if (in_flight == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase

        if (issue) begin
            addr_d = next_addr(issue_addr);
            rem_d  = rem_after;
`ifdef SAMPLE_READER_LOOP_EN
            if (rem_after == '0 && reload_loop) begin
                addr_d = reload_base;
                rem_d  = reload_num;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q            <= S_IDLE;
            addr_q             <= '0;
            rem_q              <= '0;
            done               <= 1'b0;
            bus.avm_address    <= '0;
            bus.avm_chipselect <= 1'b0;
            rd_pipe            <= '0;
        end else begin
            state_q            <= state_d;
            addr_q             <= addr_d;
            rem_q              <= rem_d;
            done               <= done_d;
            bus.avm_chipselect <= issue;
            if (issue) begin
                bus.avm_address <= issue_addr;
            end
            rd_pipe[0] <= bus.avm_chipselect;
            for (int i = 1; i < READ_LATENCY; i++) begin
                rd_pipe[i] <= rd_pipe[i-1];
            end
        end
    end

    // Returns landing while flushing (or on the stop cycle itself) belong to the aborted playback.
    assign fifo_wr     = rd_pipe[READ_LATENCY-1] && (state_q != S_FLUSH) && !fifo_clear;
    assign fifo_nempty = (fifo_cnt != '0);
    assign fifo_pop    = fifo_nempty && bus.src_ready;

    always_ff @(posedge clk) begin
        if (!reset_n || fifo_clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(fifo_wr) - CNT_W'(fifo_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= bus.avm_readdata;
        end
    end

    assign bus.src_valid      = fifo_nempty;
    assign bus.src_data       = fifo_nempty ? fifo_mem[rd_ptr] : '0;
    assign bus.avm_write      = 1'b0;
    assign bus.avm_byteenable = 4'hF;
    assign busy               = (state_q != S_IDLE);
    assign dbg_state          = state_q;
endmodule
